// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Branch-target table contents live here so the LUT and any users agree.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fetch_state_t;

  localparam logic [3:0] OPCODE_BNE         = 4'b1100;
  localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;
  localparam int unsigned BRANCH_TGT_W      = 10;

  // Constant branch-target table; unlisted indices resolve to 0.
  function automatic logic [BRANCH_TGT_W-1:0] branch_target(input logic [4:0] idx);
    logic [BRANCH_TGT_W-1:0] tgt;
    case (idx)
      5'd0:    tgt = 10'd4;
      5'd1:    tgt = 10'd12;
      5'd2:    tgt = 10'd40;
      5'd3:    tgt = 10'd7;
      5'd4:    tgt = 10'd100;
      5'd5:    tgt = 10'd200;
      5'd6:    tgt = 10'd15;
      5'd7:    tgt = 10'd1;
      5'd8:    tgt = 10'd300;
      5'd9:    tgt = 10'd511;
      5'd10:   tgt = 10'd64;
      5'd11:   tgt = 10'd1000;
      5'd12:   tgt = 10'd2;
      5'd13:   tgt = 10'd9;
      5'd14:   tgt = 10'd33;
      5'd15:   tgt = 10'd1023;
      default: tgt = 10'd0;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: start handshake, instruction memory and decoder-facing signals.
// FETCH_CYCLE_COUNT_EN adds the CycleCt run-length counter output.
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9
);

  logic               Start;
  logic [INSTR_W-1:0] ImemData;
  logic               BranchTaken;
  logic [PC_W-1:0]    ImemAddr;
  logic [INSTR_W-1:0] Instr;
  logic [3:0]         Opcode;
  logic               Valid;
  logic               Done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]        CycleCt;

  modport master (
    input  Start, ImemData, BranchTaken,
    output ImemAddr, Instr, Opcode, Valid, Done, CycleCt
  );

  modport slave (
    output Start, ImemData, BranchTaken,
    input  ImemAddr, Instr, Opcode, Valid, Done, CycleCt
  );
`else
  modport master (
    input  Start, ImemData, BranchTaken,
    output ImemAddr, Instr, Opcode, Valid, Done
  );

  modport slave (
    output Start, ImemData, BranchTaken,
    input  ImemAddr, Instr, Opcode, Valid, Done
  );
`endif

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target lookup: LUT index from the instruction -> PC target.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int unsigned LUT_IDX_W = 5,
  parameter int unsigned PC_W      = 10
) (
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);

  always_comb begin
    target_o = PC_W'(branch_target(5'(idx_i)));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IDLE/RUN/DONE sequencer, Start edge detect.
// Define FETCH_CYCLE_COUNT_EN to add the saturating RUN-cycle counter (CycleCt).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        PC_W       = 10,
  parameter int unsigned        INSTR_W    = 9,
  parameter int unsigned        LUT_IDX_W  = 5,
  parameter logic [PC_W-1:0]    START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(HALT_INSTR_DEFAULT)
) (
  input  logic         Clk,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               start_q;
  logic               done_q, done_d;
  logic               start_rise_c;
  logic               is_halt_c;
  logic               valid_c;
  logic [INSTR_W-1:0] instr_c;
  logic [PC_W-1:0]    lut_target_c;

  assign start_rise_c = bus.Start & ~start_q;
  assign is_halt_c    = (bus.ImemData == HALT_INSTR);
  // The HALT word itself is never presented as a live instruction.
  assign valid_c      = (state_q == S_RUN) && !is_halt_c;
  assign instr_c      = valid_c ? bus.ImemData : '0;

  branch_lut #(
    .LUT_IDX_W (LUT_IDX_W),
    .PC_W      (PC_W)
  ) u_branch_lut (
    .idx_i    (instr_c[LUT_IDX_W-1:0]),
    .target_o (lut_target_c)
  );

  // Next-state and next-PC selection; HALT outranks a same-cycle branch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    case (state_q)
      S_RUN: begin
        if (is_halt_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (bus.BranchTaken) begin
          pc_d = lut_target_c;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        if (start_rise_c) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= bus.Start;
      done_q  <= done_d;
    end
  end

  assign bus.ImemAddr = pc_q;
  assign bus.Instr    = instr_c;
  assign bus.Opcode   = instr_c[8:5];
  assign bus.Valid    = valid_c;
  assign bus.Done     = done_q;

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_RUN) begin
      if (cyc_q != 16'hFFFF) begin
        cyc_d = cyc_q + 16'd1;
      end
    end else if (start_rise_c) begin
      cyc_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign bus.CycleCt = cyc_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a cycle-level program-execution model.
module tb_fetch_unit;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned DEPTH   = 1 << PC_W;
  localparam logic [8:0]  HALT    = 9'h1FF;
  localparam logic [8:0]  I_ADD   = 9'h021;
  localparam logic [8:0]  I_XOR   = 9'h064;
  localparam logic [8:0]  I_BNE3  = 9'h183;

  logic clk;
  logic Reset;
  logic [8:0] imem [DEPTH];

  int n_checks;
  int n_errors;

  // Reference model: program-level view of the fetch stage
  bit m_run;
  bit m_done;
  bit m_sq;
  int m_pc;
  int m_cnt;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .LUT_IDX_W (5)
  ) dut (
    .Clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  assign bus.ImemData = imem[bus.ImemAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lut_ref(input int idx);
    int tbl [16] = '{4, 12, 40, 7, 100, 200, 15, 1, 300, 511, 64, 1000, 2, 9, 33, 1023};
    if (idx < 16) return tbl[idx];
    return 0;
  endfunction

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic tick(input logic st, input logic bt, input logic rst);
    logic [8:0] cur;
    bus.Start       = st;
    bus.BranchTaken = bt;
    Reset           = rst;
    cur = imem[m_pc];
    if (!rst) begin
      m_run = 0; m_done = 0; m_sq = 0; m_pc = 0; m_cnt = 0;
    end else begin
      if (m_run) begin
        if (cur == HALT) begin
          m_run = 0; m_done = 1;
        end else if (bt) begin
          m_pc = lut_ref(int'(cur[4:0]));
        end else begin
          m_pc = (m_pc + 1) % DEPTH;
        end
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (st && !m_sq) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
      m_sq = st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_imem(input logic [8:0] v);
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = v;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.ImemAddr !== 10'd0) begin n_errors++; $display("FAIL reset_addr: got %0d want 0", bus.ImemAddr); end
    n_checks++;
    if (bus.Valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.Valid); end
    n_checks++;
    if (bus.Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    n_checks++;
    if (bus.Instr !== 9'd0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", bus.Instr); end
`ifdef FETCH_CYCLE_COUNT_EN
    n_checks++;
    if (bus.CycleCt !== 16'd0) begin n_errors++; $display("FAIL reset_cyclect: got %0d want 0", bus.CycleCt); end
`endif
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_straight_line();
    int exp_addr [4] = '{0, 1, 2, 3};
    bit exp_val  [4] = '{1, 1, 1, 0};
    fill_imem(I_ADD);
    imem[2] = I_XOR;
    imem[3] = HALT;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus.ImemAddr !== 10'(exp_addr[i]) || bus.Valid !== exp_val[i] || bus.Done !== 1'b0) begin
        n_errors++;
        $display("FAIL straight_c%0d: addr=%0d valid=%b done=%b want addr=%0d valid=%b done=0",
                 i, bus.ImemAddr, bus.Valid, bus.Done, exp_addr[i], exp_val[i]);
      end
    end
    n_checks++;
    if (bus.Instr !== 9'd0 || bus.Opcode !== 4'd0) begin
      n_errors++; $display("FAIL straight_halt_instr: instr=%h opcode=%h want 0/0", bus.Instr, bus.Opcode);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus.Done !== 1'b1 || bus.ImemAddr !== 10'd3 || bus.Valid !== 1'b0) begin
        n_errors++;
        $display("FAIL straight_done%0d: done=%b addr=%0d valid=%b want 1/3/0", i, bus.Done, bus.ImemAddr, bus.Valid);
      end
    end
`ifdef FETCH_CYCLE_COUNT_EN
    n_checks++;
    if (bus.CycleCt !== 16'd4) begin n_errors++; $display("FAIL straight_cyclect: got %0d want 4", bus.CycleCt); end
`endif
  endtask

  task automatic test_branch();
    fill_imem(I_ADD);
    imem[2] = I_BNE3;
    imem[3] = HALT;
    imem[7] = HALT;
    for (int pass = 0; pass < 2; pass++) begin
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus.Done !== 1'b0 || bus.ImemAddr !== 10'd0) begin
        n_errors++; $display("FAIL branch_restart%0d: done=%b addr=%0d want 0/0", pass, bus.Done, bus.ImemAddr);
      end
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (bus.Opcode !== 4'b1100 || bus.Valid !== 1'b1) begin
        n_errors++; $display("FAIL branch_opcode%0d: opcode=%h valid=%b want c/1", pass, bus.Opcode, bus.Valid);
      end
      tick(1'b1, (pass == 0) ? 1'b1 : 1'b0, 1'b1);
      n_checks++;
      if (bus.ImemAddr !== ((pass == 0) ? 10'd7 : 10'd3)) begin
        n_errors++; $display("FAIL branch_target%0d: got %0d want %0d", pass, bus.ImemAddr, (pass == 0) ? 7 : 3);
      end
      tick(1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic test_halt_priority();
    fill_imem(I_ADD);
    imem[1] = HALT;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.Done !== 1'b1 || bus.ImemAddr !== 10'd1) begin
      n_errors++; $display("FAIL halt_priority: done=%b addr=%0d want 1/1", bus.Done, bus.ImemAddr);
    end
    tick(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.Done !== 1'b1 || bus.ImemAddr !== 10'd1) begin
      n_errors++; $display("FAIL done_ignores_branch: done=%b addr=%0d want 1/1", bus.Done, bus.ImemAddr);
    end
  endtask

  task automatic test_reset_mid_run();
    fill_imem(I_ADD);
    imem[10] = HALT;
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.ImemAddr !== 10'd5) begin n_errors++; $display("FAIL midrun_pc: got %0d want 5", bus.ImemAddr); end
    tick(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.ImemAddr !== 10'd0 || bus.Valid !== 1'b0 || bus.Done !== 1'b0) begin
      n_errors++; $display("FAIL midrun_reset: addr=%0d valid=%b done=%b want 0/0/0", bus.ImemAddr, bus.Valid, bus.Done);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.Valid !== 1'b0) begin n_errors++; $display("FAIL midrun_idle: valid=%b want 0", bus.Valid); end
    tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.ImemAddr !== 10'd0 || bus.Valid !== 1'b1 || bus.Instr !== I_ADD) begin
      n_errors++; $display("FAIL midrun_restart: addr=%0d valid=%b instr=%h want 0/1/%h", bus.ImemAddr, bus.Valid, bus.Instr, I_ADD);
    end
  endtask

  task automatic test_wrap_restart();
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = 9'($urandom_range(0, 255));
    imem[2] = HALT;
    // Launch at the far end of memory is impossible, so run a full lap instead.
    imem[2] = I_XOR;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < int'(DEPTH) - 1; i++) tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.ImemAddr !== 10'd1023 || bus.Valid !== 1'b1) begin
      n_errors++; $display("FAIL wrap_top: addr=%0d valid=%b want 1023/1", bus.ImemAddr, bus.Valid);
    end
    imem[2] = HALT;
    tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.ImemAddr !== 10'd0) begin n_errors++; $display("FAIL wrap_zero: got %0d want 0", bus.ImemAddr); end
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.Done !== 1'b1 || bus.ImemAddr !== 10'd2) begin
      n_errors++; $display("FAIL wrap_done: done=%b addr=%0d want 1/2", bus.Done, bus.ImemAddr);
    end
`ifdef FETCH_CYCLE_COUNT_EN
    n_checks++;
    if (bus.CycleCt !== 16'(DEPTH + 3)) begin
      n_errors++; $display("FAIL wrap_cyclect: got %0d want %0d", bus.CycleCt, DEPTH + 3);
    end
    tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.CycleCt !== 16'(DEPTH + 3)) begin
      n_errors++; $display("FAIL wrap_cyclect_hold: got %0d want %0d", bus.CycleCt, DEPTH + 3);
    end
`endif
    tick(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.Done !== 1'b1) begin n_errors++; $display("FAIL restart_done_held: got %b want 1", bus.Done); end
    tick(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (bus.Done !== 1'b0 || bus.ImemAddr !== 10'd0 || bus.Valid !== 1'b1) begin
      n_errors++; $display("FAIL restart: done=%b addr=%0d valid=%b want 0/0/1", bus.Done, bus.ImemAddr, bus.Valid);
    end
  endtask

  task automatic test_random();
    logic st;
    logic bt;
    logic rst;
    logic [8:0] exp_instr;
    bit exp_valid;
    for (int i = 0; i < int'(DEPTH); i++)
      imem[i] = ($urandom_range(0, 29) == 0) ? HALT : 9'($urandom_range(0, 510));
    st = bus.Start;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) st = ~st;
      bt  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick(st, bt, rst);
      exp_valid = m_run && (imem[m_pc] != HALT);
      exp_instr = exp_valid ? imem[m_pc] : 9'd0;
      n_checks++;
      if (bus.ImemAddr !== 10'(m_pc) || bus.Valid !== exp_valid || bus.Instr !== exp_instr ||
          bus.Opcode !== exp_instr[8:5] || bus.Done !== m_done) begin
        n_errors++;
        $display("FAIL random_c%0d: addr=%0d valid=%b instr=%h op=%h done=%b want %0d/%b/%h/%h/%b",
                 c, bus.ImemAddr, bus.Valid, bus.Instr, bus.Opcode, bus.Done,
                 m_pc, exp_valid, exp_instr, exp_instr[8:5], m_done);
      end
`ifdef FETCH_CYCLE_COUNT_EN
      n_checks++;
      if (bus.CycleCt !== 16'(m_cnt)) begin
        n_errors++; $display("FAIL random_cyclect_c%0d: got %0d want %0d", c, bus.CycleCt, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_run = 0; m_done = 0; m_sq = 0; m_pc = 0; m_cnt = 0;
    Reset = 1'b0;
    bus.Start = 1'b0;
    bus.BranchTaken = 1'b0;
    fill_imem(I_ADD);
    test_reset();
    test_straight_line();
    test_branch();
    test_halt_priority();
    test_reset_mid_run();
    test_wrap_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
